// File: rtl/cia_bus_arbiter_pkg.sv
// cia_bus_arbiter_pkg: shared FSM states, requester encoding and CIA register map
package cia_bus_arbiter_pkg;

    typedef enum logic [1:0] {IDLE, WAIT_PHI, STROBE, CAPTURE} state_e;

    typedef enum logic {SEL_CPU = 1'b0, SEL_DBG = 1'b1} sel_e;

    localparam logic [3:0] REG_PRA    = 4'h0;
    localparam logic [3:0] REG_PRB    = 4'h1;
    localparam logic [3:0] REG_DDRA   = 4'h2;
    localparam logic [3:0] REG_DDRB   = 4'h3;
    localparam logic [3:0] REG_TALO   = 4'h4;
    localparam logic [3:0] REG_TAHI   = 4'h5;
    localparam logic [3:0] REG_TBLO   = 4'h6;
    localparam logic [3:0] REG_TBHI   = 4'h7;
    localparam logic [3:0] REG_TOD10  = 4'h8;
    localparam logic [3:0] REG_TODSEC = 4'h9;
    localparam logic [3:0] REG_TODMIN = 4'hA;
    localparam logic [3:0] REG_TODHR  = 4'hB;
    localparam logic [3:0] REG_SDR    = 4'hC;
    localparam logic [3:0] REG_ICR    = 4'hD;
    localparam logic [3:0] REG_CRA    = 4'hE;
    localparam logic [3:0] REG_CRB    = 4'hF;

endpackage

// File: rtl/cia_bus_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin select; on a tie the requester not granted last wins
module rr_arb2
    import cia_bus_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  sel_e       last_i,
    output logic       valid_o,
    output sel_e       sel_o
);

    always_comb begin
        valid_o = |req_i;
        sel_o   = (&req_i) ? ((last_i == SEL_CPU) ? SEL_DBG : SEL_CPU)
                           : (req_i[1] ? SEL_DBG : SEL_CPU);
    end

endmodule

// File: rtl/cia_bus_arbiter.sv
// cia_bus_arbiter: shares one CIA bus between a CPU and a debug requester, one phi2-timed access at a time
module cia_bus_arbiter
    import cia_bus_arbiter_pkg::*;
#(
    parameter bit DBG_ICR_READ = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       phi2,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [3:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic       cpu_ack,
    output logic [7:0] cpu_rdata,
    input  logic       dbg_req,
    input  logic       dbg_we,
    input  logic [3:0] dbg_addr,
    input  logic [7:0] dbg_wdata,
    output logic       dbg_ack,
    output logic [7:0] dbg_rdata,
    output logic       dbg_err,
    output logic       cia_cs_n,
    output logic       cia_rw,
    output logic [3:0] cia_rs,
    output logic [7:0] cia_db_in,
    input  logic [7:0] cia_db_out,
    output logic       busy
);

    state_e     state_q, state_d;
    sel_e       sel_q, sel_d, last_q, last_d, win;
    logic       win_valid, win_we, bypass;
    logic [3:0] win_addr;
    logic [7:0] win_wdata;
    logic       we_q, we_d;
    logic [3:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       cs_n_q, cs_n_d, rw_q, rw_d;
    logic [3:0] rs_q, rs_d;
    logic [7:0] db_in_q, db_in_d;
    logic       cpu_ack_q, cpu_ack_d, dbg_ack_q, dbg_ack_d, dbg_err_q, dbg_err_d;
    logic [7:0] cpu_rdata_q, cpu_rdata_d, dbg_rdata_q, dbg_rdata_d;
    logic       busy_q, busy_d;
    logic [1:0] elig;

    // A requester being acked this cycle still shows its old req; masking it avoids a repeat access.
    assign elig = {dbg_req & ~dbg_ack_q, cpu_req & ~cpu_ack_q};

    rr_arb2 u_rr (
        .req_i   (elig),
        .last_i  (last_q),
        .valid_o (win_valid),
        .sel_o   (win)
    );

    assign win_we    = (win == SEL_DBG) ? dbg_we    : cpu_we;
    assign win_addr  = (win == SEL_DBG) ? dbg_addr  : cpu_addr;
    assign win_wdata = (win == SEL_DBG) ? dbg_wdata : cpu_wdata;
    assign bypass    = (win == SEL_DBG) && !dbg_we && (dbg_addr == REG_ICR) && !DBG_ICR_READ;

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        last_d      = last_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cs_n_d      = 1'b1;
        rw_d        = 1'b1;
        rs_d        = rs_q;
        db_in_d     = db_in_q;
        cpu_ack_d   = 1'b0;
        dbg_ack_d   = 1'b0;
        dbg_err_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        case (state_q)
            IDLE: if (win_valid) begin
                last_d  = win;
                sel_d   = win;
                we_d    = win_we;
                addr_d  = win_addr;
                wdata_d = win_wdata;
                // Blocked ICR reads would clear pending interrupts; answer locally with an error.
                if (bypass) begin
                    dbg_ack_d   = 1'b1;
                    dbg_err_d   = 1'b1;
                    dbg_rdata_d = 8'h00;
                end else begin
                    state_d = WAIT_PHI;
                end
            end
            WAIT_PHI: if (phi2) begin
                cs_n_d  = 1'b0;
                rw_d    = ~we_q;
                rs_d    = addr_q;
                db_in_d = wdata_q;
                state_d = STROBE;
            end
            STROBE: state_d = CAPTURE;
            CAPTURE: begin
                state_d = IDLE;
                if (sel_q == SEL_CPU) begin
                    cpu_ack_d   = 1'b1;
                    cpu_rdata_d = we_q ? cpu_rdata_q : cia_db_out;
                end else begin
                    dbg_ack_d   = 1'b1;
                    dbg_rdata_d = we_q ? dbg_rdata_q : cia_db_out;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            sel_q       <= SEL_CPU;
            last_q      <= SEL_DBG;
            we_q        <= 1'b0;
            addr_q      <= 4'h0;
            wdata_q     <= 8'h00;
            cs_n_q      <= 1'b1;
            rw_q        <= 1'b1;
            rs_q        <= 4'h0;
            db_in_q     <= 8'h00;
            cpu_ack_q   <= 1'b0;
            dbg_ack_q   <= 1'b0;
            dbg_err_q   <= 1'b0;
            cpu_rdata_q <= 8'h00;
            dbg_rdata_q <= 8'h00;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cs_n_q      <= cs_n_d;
            rw_q        <= rw_d;
            rs_q        <= rs_d;
            db_in_q     <= db_in_d;
            cpu_ack_q   <= cpu_ack_d;
            dbg_ack_q   <= dbg_ack_d;
            dbg_err_q   <= dbg_err_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign cpu_ack   = cpu_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dbg_ack   = dbg_ack_q;
    assign dbg_rdata = dbg_rdata_q;
    assign dbg_err   = dbg_err_q;
    assign cia_cs_n  = cs_n_q;
    assign cia_rw    = rw_q;
    assign cia_rs    = rs_q;
    assign cia_db_in = db_in_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_cia_bus_arbiter.sv
// tb_cia_bus_arbiter: directed checks of arbitration, strobe timing, ICR bypass and reset abort
module tb_cia_bus_arbiter;

    logic       clk, reset_n, phi2;
    logic       cpu_req, cpu_we, dbg_req, dbg_we;
    logic [3:0] cpu_addr, dbg_addr;
    logic [7:0] cpu_wdata, dbg_wdata, cia_db_val;
    logic       cpu_ack, dbg_ack, dbg_err, cia_cs_n, cia_rw, busy;
    logic [7:0] cpu_rdata, dbg_rdata, cia_db_in;
    logic [3:0] cia_rs;

    logic       b_dbg_req, b_dbg_we;
    logic [3:0] b_dbg_addr;
    logic [7:0] b_dbg_wdata;
    logic       b_cpu_ack, b_dbg_ack, b_dbg_err, b_cs_n, b_rw, b_busy;
    logic [7:0] b_cpu_rdata, b_dbg_rdata, b_db_in;
    logic [3:0] b_rs;

    int n_cmp = 0, n_bad = 0;
    int strb = 0, b_strb = 0, cs_long = 0, rw_bad = 0, err_bad = 0, n_cack = 0, n_dack = 0;
    logic       prev_low = 1'b0, s_rw;
    logic [3:0] s_rs;
    logic [7:0] s_db;

    cia_bus_arbiter #(.DBG_ICR_READ(1'b0)) dut (
        .clk(clk), .reset_n(reset_n), .phi2(phi2),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
        .cia_cs_n(cia_cs_n), .cia_rw(cia_rw), .cia_rs(cia_rs), .cia_db_in(cia_db_in),
        .cia_db_out(cia_db_val), .busy(busy)
    );

    cia_bus_arbiter #(.DBG_ICR_READ(1'b1)) dut_b (
        .clk(clk), .reset_n(reset_n), .phi2(phi2),
        .cpu_req(1'b0), .cpu_we(1'b0), .cpu_addr(4'h0), .cpu_wdata(8'h00),
        .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata),
        .dbg_req(b_dbg_req), .dbg_we(b_dbg_we), .dbg_addr(b_dbg_addr), .dbg_wdata(b_dbg_wdata),
        .dbg_ack(b_dbg_ack), .dbg_rdata(b_dbg_rdata), .dbg_err(b_dbg_err),
        .cia_cs_n(b_cs_n), .cia_rw(b_rw), .cia_rs(b_rs), .cia_db_in(b_db_in),
        .cia_db_out(cia_db_val), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        int cnt;
        cnt  = 0;
        phi2 = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            phi2 = (cnt == 15);
            cnt  = (cnt + 1) % 16;
        end
    end

    always @(negedge clk) begin
        if (!cia_cs_n) begin
            strb++;
            s_rw = cia_rw;
            s_rs = cia_rs;
            s_db = cia_db_in;
            if (prev_low) cs_long++;
        end
        prev_low = !cia_cs_n;
        if (cia_cs_n && !cia_rw) rw_bad++;
        if (dbg_err && !dbg_ack) err_bad++;
        if (cpu_ack) n_cack++;
        if (dbg_ack) n_dack++;
        if (!b_cs_n) b_strb++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Raises both requests together, re-presents each until it has nc / nd acks, logs ack order (0=CPU, 1=DBG).
    task automatic serve(input int nc, input int nd, output logic [7:0] seq, output int lat,
                         output logic [7:0] crd, output logic [7:0] drd, output logic derr);
        int cc, dc;
        bit done;
        cc = 0; dc = 0; seq = 8'h00; lat = -1; crd = 8'h00; drd = 8'h00; derr = 1'b0; done = 1'b0;
        cpu_req = (nc > 0);
        dbg_req = (nd > 0);
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (cpu_ack) begin seq = {seq[6:0], 1'b0}; cc++; crd = cpu_rdata; if (lat < 0) lat = i; end
            if (dbg_ack) begin seq = {seq[6:0], 1'b1}; dc++; drd = dbg_rdata; derr = dbg_err; if (lat < 0) lat = i; end
            done = (cc >= nc) && (dc >= nd);
            @(posedge clk);
            #1;
            cpu_req = (cc < nc);
            dbg_req = (dc < nd);
        end
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        chk("serve_done", done, 1);
    endtask

    initial begin
        logic [7:0] seq, crd, drd;
        logic       derr, hit, b_err;
        logic [7:0] b_rd;
        int         lat, s0, a0;
        reset_n = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
        b_dbg_req = 0; b_dbg_we = 0; b_dbg_addr = 0; b_dbg_wdata = 0;
        cia_db_val = 8'h00;
        #3 reset_n = 1'b0;
        #1;
        chk("rst_cs_n", cia_cs_n, 1);
        chk("rst_rw", cia_rw, 1);
        chk("rst_rs", cia_rs, 0);
        chk("rst_db_in", cia_db_in, 0);
        chk("rst_acks", {cpu_ack, dbg_ack, dbg_err}, 0);
        chk("rst_rdata", {cpu_rdata, dbg_rdata}, 0);
        chk("rst_busy", busy, 0);
        idle(3);
        reset_n = 1'b1;

        // tie straight out of reset: CPU, then DBG, alternating
        cpu_we = 0; cpu_addr = 4'h2; dbg_we = 0; dbg_addr = 4'h3; cia_db_val = 8'h3C;
        serve(2, 2, seq, lat, crd, drd, derr);
        chk("tie_order", seq, 8'h05);
        chk("tie_dbg_rdata", drd, 8'h3C);
        idle(4);

        // CPU write 0x34 to register 4
        s0 = strb; a0 = n_cack;
        cpu_we = 1; cpu_addr = 4'h4; cpu_wdata = 8'h34;
        serve(1, 0, seq, lat, crd, drd, derr);
        chk("wr_latency_ok", (lat >= 4) && (lat <= 19), 1);
        idle(20);
        chk("wr_no_dup_strobe", strb - s0, 1);
        chk("wr_strobe_rw", s_rw, 0);
        chk("wr_strobe_rs", s_rs, 4'h4);
        chk("wr_strobe_db", s_db, 8'h34);
        chk("wr_ack_pulses", n_cack - a0, 1);

        // CPU read of register 1
        s0 = strb;
        cpu_we = 0; cpu_addr = 4'h1; cia_db_val = 8'hA5;
        serve(1, 0, seq, lat, crd, drd, derr);
        chk("rd_cpu_rdata", crd, 8'hA5);
        chk("rd_strobe_rw", s_rw, 1);
        chk("rd_strobe_rs", s_rs, 4'h1);
        chk("rd_strobes", strb - s0, 1);

        // last grant was CPU, so a fresh tie goes to DBG
        idle(2);
        dbg_we = 0; dbg_addr = 4'h3;
        serve(1, 1, seq, lat, crd, drd, derr);
        chk("tie2_order", seq, 8'h02);
        chk("tie2_dbg_rdata", drd, 8'hA5);

        // debug write to ICR goes through
        idle(2);
        s0 = strb;
        dbg_we = 1; dbg_addr = 4'hD; dbg_wdata = 8'h5A;
        serve(0, 1, seq, lat, crd, drd, derr);
        chk("dbg_wr_icr_strobes", strb - s0, 1);
        chk("dbg_wr_icr_rs", s_rs, 4'hD);
        chk("dbg_wr_icr_db", s_db, 8'h5A);
        chk("dbg_wr_icr_err", derr, 0);

        // debug read of ICR is answered locally
        idle(2);
        s0 = strb;
        dbg_we = 0; dbg_addr = 4'hD; cia_db_val = 8'h77;
        serve(0, 1, seq, lat, crd, drd, derr);
        chk("icr_bypass_latency", lat, 1);
        chk("icr_bypass_err", derr, 1);
        chk("icr_bypass_rdata", drd, 8'h00);
        idle(20);
        chk("icr_bypass_strobes", strb - s0, 0);

        // same read with ICR reads allowed
        s0 = b_strb; hit = 0; b_err = 1'b1; b_rd = 8'h00;
        b_dbg_we = 0; b_dbg_addr = 4'hD; b_dbg_req = 1;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            if (b_dbg_ack) begin hit = 1; b_err = b_dbg_err; b_rd = b_dbg_rdata; end
        end
        idle(1);
        b_dbg_req = 0;
        chk("icr_allowed_ack", hit, 1);
        chk("icr_allowed_err", b_err, 0);
        chk("icr_allowed_rdata", b_rd, 8'h77);
        chk("icr_allowed_strobes", b_strb - s0, 1);

        // reset in the middle of a strobe
        idle(2);
        a0 = n_cack + n_dack; hit = 0;
        cpu_we = 1; cpu_addr = 4'h5; cpu_wdata = 8'h11; cpu_req = 1;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            hit = !cia_cs_n;
        end
        chk("rst_strobe_seen", hit, 1);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_mid_cs_n", cia_cs_n, 1);
        chk("rst_mid_busy", busy, 0);
        cpu_req = 0;
        idle(3);
        reset_n = 1'b1;
        idle(20);
        chk("rst_mid_no_ack", (n_cack + n_dack) - a0, 0);

        // normal service after the aborted access
        cpu_we = 0; cpu_addr = 4'h6; cia_db_val = 8'hC3;
        serve(1, 0, seq, lat, crd, drd, derr);
        chk("post_rst_rdata", crd, 8'hC3);
        chk("post_rst_latency_ok", (lat >= 4) && (lat <= 19), 1);

        chk("cs_low_one_cycle", cs_long, 0);
        chk("rw_high_outside_strobe", rw_bad, 0);
        chk("err_only_with_ack", err_bad, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cia_bus_arbiter.md
CIA_BUS_ARBITER -- requirements
Module: cia_bus_arbiter

Interface
REQ-001 SHALL have parameter DBG_ICR_READ, default 0, meaning 1 allows debug reads of register 0xD and 0 blocks them.
REQ-002 SHALL have port clk, input, 1, system clock.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port phi2, input, 1, single-clk-cycle bus-phase enable pulse.
REQ-005 SHALL have CPU requester ports: cpu_req in 1, cpu_we in 1, cpu_addr in 4, cpu_wdata in 8, cpu_ack out 1, cpu_rdata out 8.
REQ-006 SHALL have debug requester ports: dbg_req in 1, dbg_we in 1, dbg_addr in 4, dbg_wdata in 8, dbg_ack out 1, dbg_rdata out 8, dbg_err out 1.
REQ-007 SHALL have CIA-side ports: cia_cs_n out 1, cia_rw out 1, cia_rs out 4, cia_db_in out 8 (write data to CIA), cia_db_out in 8 (read data from CIA).
REQ-008 SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.
REQ-009 SHALL register every output.

Function
REQ-010 SHALL implement FSM states IDLE, WAIT_PHI, STROBE, CAPTURE.
REQ-011 IDLE: on any eligible req, SHALL grant, latch we/addr/wdata of the winner and go to WAIT_PHI; with no eligible req, SHALL stay in IDLE.
REQ-012 WAIT_PHI: in the cycle phi2=1, SHALL load cia_cs_n=0, cia_rw=~we, cia_rs=addr and cia_db_in=wdata, then go to STROBE.
REQ-013 STROBE: cia_cs_n SHALL be low for exactly this one clk cycle; the FSM SHALL then raise cia_cs_n and go to CAPTURE.
REQ-014 CAPTURE: SHALL register cia_db_out into the granted requester's rdata on reads (rdata unchanged on writes), pulse its ack for one cycle, and go to IDLE.
REQ-015 Grant-to-ack latency SHALL be 3 cycles plus the wait for phi2, i.e. 3..(phi2 period + 2) cycles.
REQ-016 Arbitration SHALL be round-robin with a last-grant pointer; when both requesters are eligible, the one not last granted wins.
REQ-017 Handshake: req, we, addr and wdata SHALL be held stable until ack; the requester SHALL drop req or present a new request after ack.
REQ-018 The requester whose ack is high in the current cycle SHALL be ineligible for a grant in that cycle, so a stale req cannot trigger a duplicate access.
REQ-019 Only one CIA access SHALL be in flight; the non-granted request SHALL wait without loss.
REQ-020 With DBG_ICR_READ=0, a debug read of addr 0xD SHALL bypass the CIA: no cia_cs_n pulse, dbg_rdata=0x00, and dbg_err=1 together with dbg_ack in the cycle after grant.
REQ-021 Debug writes to 0xD SHALL proceed normally.
REQ-022 dbg_err SHALL be high only together with dbg_ack.
REQ-023 cia_rw SHALL return to 1 and cia_rs and cia_db_in SHALL hold their values outside STROBE.
REQ-024 A request arriving in the same cycle as phi2 SHALL wait for the next phi2, because the grant occurs in IDLE and the strobe is launched only from WAIT_PHI.

Reset
REQ-025 On reset_n low, the block SHALL immediately apply: state IDLE, cia_cs_n=1, cia_rw=1, cia_rs=0, cia_db_in=0x00, cpu_ack=0, dbg_ack=0, cpu_rdata=0x00, dbg_rdata=0x00, dbg_err=0, busy=0, last-grant pointer=debug (so the CPU wins the first tie).
REQ-026 A reset during STROBE SHALL abort the access with cia_cs_n forced high at once, and no ack SHALL follow.

Structure
REQ-027 A shared package SHALL hold the FSM state enum, the CIA register-address constants (including ICR = 4'hD), and the requester-select encoding (CPU=0, DBG=1).
REQ-028 The block SHALL be a single module; the round-robin select MAY be a sub-module rr_arb2.

Verification
REQ-029 SHALL cover: phi2 every 16 cycles, CPU write addr 0x4 data 0x34 -> exactly one cia_cs_n low cycle with rw=0, rs=4, db_in=0x34, then cpu_ack one pulse.
REQ-030 SHALL cover: CPU read addr 0x1 with the CIA model returning 0xA5 -> cpu_rdata=0xA5 when cpu_ack=1, and cia_rw=1 during the strobe.
REQ-031 SHALL cover: cpu_req and dbg_req raised in the same cycle from reset -> CPU served first, debug second; repeated ties alternate CPU, DBG, CPU.
REQ-032 SHALL cover: debug read addr 0xD with DBG_ICR_READ=0 -> no strobe, dbg_ack=1, dbg_err=1, dbg_rdata=0x00; with DBG_ICR_READ=1 -> normal strobe and dbg_err=0.
REQ-033 SHALL cover: req held high for one cycle past ack -> no second strobe.
REQ-034 SHALL cover: reset_n asserted during STROBE -> cia_cs_n=1 immediately, no ack, and the next request after reset is served normally.
